// File: rtl/program_counter.sv
// Hack CPU program counter: reset > load > call > ret > inc > hold, with out as a pure register.
// Define PC_RET_STACK_EN to build the DEPTH-entry hardware return-address stack for call/ret.
module program_counter #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  input  logic         call,
  input  logic         ret,
  input  logic [W-1:0] in,
  output logic [W-1:0] out,
  output logic         stk_full,
  output logic         stk_empty,
  output logic         stk_err
);

  logic [W-1:0] out_r;
  logic [W-1:0] out_nxt_s;
  logic [W-1:0] out_inc_s;

  assign out       = out_r;
  assign out_inc_s = out_r + W'(1);

`ifdef PC_RET_STACK_EN
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  stack_r [DEPTH];
  logic [AW:0]   cnt_r;
  logic [AW:0]   cnt_nxt_s;
  logic [AW:0]   cnt_dec_s;
  logic [AW-1:0] top_idx_s;
  logic          err_r;
  logic          err_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          push_s;

  assign cnt_dec_s = cnt_r - (AW+1)'(1);
  assign top_idx_s = cnt_dec_s[AW-1:0];

  assign stk_full  = full_r;
  assign stk_empty = empty_r;
  assign stk_err   = err_r;

  // Next-state selection by strict priority; a full-stack call still jumps but drops its return address.
  always_comb begin
    out_nxt_s = out_r;
    cnt_nxt_s = cnt_r;
    err_nxt_s = err_r;
    push_s    = 1'b0;
    if (reset) begin
      out_nxt_s = {W{1'b0}};
      cnt_nxt_s = {(AW+1){1'b0}};
      err_nxt_s = 1'b0;
    end else if (load) begin
      out_nxt_s = in;
    end else if (call) begin
      out_nxt_s = in;
      if (!full_r) begin
        push_s    = 1'b1;
        cnt_nxt_s = cnt_r + (AW+1)'(1);
      end else begin
        err_nxt_s = 1'b1;
      end
    end else if (ret) begin
      if (!empty_r) begin
        out_nxt_s = stack_r[top_idx_s];
        cnt_nxt_s = cnt_dec_s;
      end else begin
        err_nxt_s = 1'b1;
      end
    end else if (inc) begin
      out_nxt_s = out_inc_s;
    end else begin
      out_nxt_s = out_r;
    end
  end

  // PC, depth counter and flags; full/empty are registered alongside the counter they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r   <= {W{1'b0}};
      cnt_r   <= {(AW+1){1'b0}};
      err_r   <= 1'b0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      out_r   <= out_nxt_s;
      cnt_r   <= cnt_nxt_s;
      err_r   <= err_nxt_s;
      full_r  <= (cnt_nxt_s == (AW+1)'(DEPTH));
      empty_r <= (cnt_nxt_s == {(AW+1){1'b0}});
    end
  end

  // Return-address storage; contents are meaningless above cnt, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      stack_r[cnt_r[AW-1:0]] <= out_inc_s;
    end
  end

`else
  logic unused_stack_s;

  assign unused_stack_s = ret ^ (DEPTH > 1);
  assign stk_full       = 1'b0;
  assign stk_empty      = 1'b1;
  assign stk_err        = 1'b0;

  // Without the stack, call is just a jump and ret falls through to inc/hold.
  always_comb begin
    out_nxt_s = out_r;
    if (reset) begin
      out_nxt_s = {W{1'b0}};
    end else if (load || call) begin
      out_nxt_s = in;
    end else if (inc) begin
      out_nxt_s = out_inc_s;
    end else begin
      out_nxt_s = out_r;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= {W{1'b0}};
    end else begin
      out_r <= out_nxt_s;
    end
  end
`endif

endmodule
